// File: rtl/bus_sel_pkg.sv
// Bus-source codes, source count and sequencer state encoding shared by the
// bus drive sequencer and its select decoder.
package bus_sel_pkg;

   localparam int NUM_SRC = 24;
   localparam int SEL_W   = 5;

   typedef enum logic [4:0] {
      SRC_R0  = 5'd0,  SRC_R1  = 5'd1,  SRC_R2  = 5'd2,  SRC_R3  = 5'd3,
      SRC_R4  = 5'd4,  SRC_R5  = 5'd5,  SRC_R6  = 5'd6,  SRC_R7  = 5'd7,
      SRC_R8  = 5'd8,  SRC_R9  = 5'd9,  SRC_R10 = 5'd10, SRC_R11 = 5'd11,
      SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15,
      SRC_HI  = 5'd16, SRC_LO  = 5'd17, SRC_ZHI = 5'd18, SRC_ZLO = 5'd19,
      SRC_PC  = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22, SRC_C = 5'd23,
      SRC_NONE = 5'd31
   } src_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2
   } state_e;

endpackage

// File: rtl/onehot_decode5_32.sv
// Combinational source code to one-hot enable decode; valid flags codes below N.
// Zero latency, no flow control.
module onehot_decode5_32
   import bus_sel_pkg::*;
#(
   parameter int N = NUM_SRC,
   parameter int W = SEL_W
) (
   input  logic [W-1:0] sel,
   output logic [N-1:0] onehot,
   output logic         valid
);

   always_comb begin
      onehot = '0;
      valid  = (int'(sel) < N);
      for (int i = 0; i < N; i++) begin
         if (int'(sel) == i) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/bus_drive_sequencer.sv
// Registered one-hot bus-source enables with per-grant hold length and idle turnaround
// between sources; 1-cycle accept-to-drive, req_ready only in IDLE or last drive cycle.
// Define BUS_DRIVE_STATS_EN to build the saturating drive/turn cycle counters.
module bus_drive_sequencer #(
   parameter int NUM_SRC    = bus_sel_pkg::NUM_SRC,
   parameter int SEL_W      = bus_sel_pkg::SEL_W,
   parameter int LEN_W      = 3,
   parameter int TURNAROUND = 1
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               req_valid,
   input  logic [SEL_W-1:0]   req_sel,
   input  logic [LEN_W-1:0]   req_len,
   output logic               req_ready,
   output logic [NUM_SRC-1:0] drive_en,
   output logic               bus_idle,
   output logic               err_bad_sel,
   output logic [15:0]        drive_cycles,
   output logic [15:0]        turn_cycles
);
   import bus_sel_pkg::*;

   localparam logic [7:0] TURN_LAST = (TURNAROUND > 0) ? 8'(TURNAROUND - 1) : 8'd0;

   state_e             state;
   logic [LEN_W-1:0]   cnt;
   logic [LEN_W-1:0]   len_m1;
   logic [LEN_W-1:0]   pend_len;
   logic [SEL_W-1:0]   cur_sel;
   logic [SEL_W-1:0]   pend_sel;
   logic [SEL_W-1:0]   dec_sel;
   logic               pend_vld;
   logic [7:0]         turn_cnt;
   logic [NUM_SRC-1:0] dec_onehot;
   logic               dec_valid;
   logic               accept;
   logic               acc_drive;
   logic               acc_bad;

   // While turning around nothing is accepted, so the decoder serves the pending code.
   assign dec_sel = (state == TURN) ? pend_sel : req_sel;

   onehot_decode5_32 #(
      .N (NUM_SRC),
      .W (SEL_W)
   ) u_decode (
      .sel    (dec_sel),
      .onehot (dec_onehot),
      .valid  (dec_valid)
   );

   assign req_ready = (state == IDLE) || ((state == DRIVE) && (cnt == '0));
   assign accept    = req_valid && req_ready;
   assign acc_drive = accept && dec_valid;
   assign acc_bad   = accept && !dec_valid && (req_sel != SEL_W'(SRC_NONE));
   assign len_m1    = (req_len == '0) ? '0 : req_len - 1'b1;
   assign bus_idle  = (drive_en == '0);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state       <= IDLE;
         drive_en    <= '0;
         err_bad_sel <= 1'b0;
         cnt         <= '0;
         cur_sel     <= '0;
         pend_vld    <= 1'b0;
         pend_sel    <= '0;
         pend_len    <= '0;
         turn_cnt    <= '0;
      end else begin
         err_bad_sel <= acc_bad;
         case (state)
            IDLE: begin
               if (acc_drive) begin
                  state    <= DRIVE;
                  drive_en <= dec_onehot;
                  cur_sel  <= req_sel;
                  cnt      <= len_m1;
               end
            end
            DRIVE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (acc_drive && (req_sel == cur_sel)) begin
                  cnt <= len_m1;
               end else if (acc_drive && (TURNAROUND == 0)) begin
                  drive_en <= dec_onehot;
                  cur_sel  <= req_sel;
                  cnt      <= len_m1;
               end else begin
                  drive_en <= '0;
                  if (TURNAROUND == 0) begin
                     state <= IDLE;
                  end else begin
                     state    <= TURN;
                     turn_cnt <= '0;
                     pend_vld <= acc_drive;
                     pend_sel <= req_sel;
                     pend_len <= len_m1;
                  end
               end
            end
            TURN: begin
               if (turn_cnt != TURN_LAST) begin
                  turn_cnt <= turn_cnt + 8'd1;
               end else if (pend_vld) begin
                  state    <= DRIVE;
                  drive_en <= dec_onehot;
                  cur_sel  <= pend_sel;
                  cnt      <= pend_len;
                  pend_vld <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               drive_en <= '0;
            end
         endcase
      end
   end

`ifdef BUS_DRIVE_STATS_EN
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         drive_cycles <= '0;
         turn_cycles  <= '0;
      end else begin
         if (!bus_idle && (drive_cycles != 16'hFFFF)) drive_cycles <= drive_cycles + 16'd1;
         if ((state == TURN) && (turn_cycles != 16'hFFFF)) turn_cycles <= turn_cycles + 16'd1;
      end
   end
`else
   assign drive_cycles = '0;
   assign turn_cycles  = '0;
`endif

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// Directed table-driven bench for bus_drive_sequencer plus hand sequences for
// asynchronous clear and the stats counters.
module tb_bus_drive_sequencer;

   logic        clk = 1'b0;
   logic        clr;
   logic        req_valid;
   logic [4:0]  req_sel;
   logic [2:0]  req_len;
   logic        req_ready;
   logic [23:0] drive_en;
   logic        bus_idle;
   logic        err_bad_sel;
   logic [15:0] drive_cycles;
   logic [15:0] turn_cycles;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        vld;
      logic [4:0]  sel;
      logic [2:0]  len;
      logic        rdy;   // req_ready during the cycle the inputs are applied
      logic [23:0] drv;   // drive_en after the following clock edge
      logic        err;   // err_bad_sel after the following clock edge
   } vec_t;

   vec_t vec [24];
   vec_t t;

   bus_drive_sequencer dut (
      .clk          (clk),
      .clr          (clr),
      .req_valid    (req_valid),
      .req_sel      (req_sel),
      .req_len      (req_len),
      .req_ready    (req_ready),
      .drive_en     (drive_en),
      .bus_idle     (bus_idle),
      .err_bad_sel  (err_bad_sel),
      .drive_cycles (drive_cycles),
      .turn_cycles  (turn_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   // Called at a falling edge: apply inputs, check ready, then check the registered outputs.
   task automatic step(input vec_t v, input string tag, input int idx);
      req_valid = v.vld;
      req_sel   = v.sel;
      req_len   = v.len;
      #1;
      chk({tag, "_ready"}, idx, 32'(req_ready), 32'(v.rdy));
      @(negedge clk);
      chk({tag, "_drive_en"}, idx, 32'(drive_en), 32'(v.drv));
      chk({tag, "_bus_idle"}, idx, 32'(bus_idle), 32'(v.drv == 24'h0));
      chk({tag, "_err"}, idx, 32'(err_bad_sel), 32'(v.err));
   endtask

   initial begin
      clr       = 1'b1;
      req_valid = 1'b0;
      req_sel   = 5'd31;
      req_len   = 3'd0;

      // PC for one cycle, then turnaround, then idle
      vec[0]  = '{1'b1, 5'd20, 3'd1, 1'b1, 24'h100000, 1'b0};
      vec[1]  = '{1'b0, 5'd0,  3'd0, 1'b1, 24'h000000, 1'b0};
      vec[2]  = '{1'b0, 5'd0,  3'd0, 1'b0, 24'h000000, 1'b0};
      vec[3]  = '{1'b0, 5'd0,  3'd0, 1'b1, 24'h000000, 1'b0};
      // R5 len 3 extended by R5 len 2 with no gap; a request while not ready is ignored
      vec[4]  = '{1'b1, 5'd5,  3'd3, 1'b1, 24'h000020, 1'b0};
      vec[5]  = '{1'b1, 5'd9,  3'd1, 1'b0, 24'h000020, 1'b0};
      vec[6]  = '{1'b0, 5'd0,  3'd0, 1'b0, 24'h000020, 1'b0};
      vec[7]  = '{1'b1, 5'd5,  3'd2, 1'b1, 24'h000020, 1'b0};
      vec[8]  = '{1'b0, 5'd0,  3'd0, 1'b0, 24'h000020, 1'b0};
      vec[9]  = '{1'b0, 5'd0,  3'd0, 1'b1, 24'h000000, 1'b0};
      vec[10] = '{1'b0, 5'd0,  3'd0, 1'b0, 24'h000000, 1'b0};
      // MDR len 2, then HI (len 0 -> 1) after one turnaround cycle
      vec[11] = '{1'b1, 5'd21, 3'd2, 1'b1, 24'h200000, 1'b0};
      vec[12] = '{1'b0, 5'd0,  3'd0, 1'b0, 24'h200000, 1'b0};
      vec[13] = '{1'b1, 5'd16, 3'd0, 1'b1, 24'h000000, 1'b0};
      vec[14] = '{1'b0, 5'd0,  3'd0, 1'b0, 24'h010000, 1'b0};
      vec[15] = '{1'b0, 5'd0,  3'd0, 1'b1, 24'h000000, 1'b0};
      vec[16] = '{1'b0, 5'd0,  3'd0, 1'b0, 24'h000000, 1'b0};
      // NONE is silent, 27 pulses the error once
      vec[17] = '{1'b1, 5'd31, 3'd1, 1'b1, 24'h000000, 1'b0};
      vec[18] = '{1'b1, 5'd27, 3'd1, 1'b1, 24'h000000, 1'b1};
      vec[19] = '{1'b0, 5'd0,  3'd0, 1'b1, 24'h000000, 1'b0};
      // Illegal code on the last drive cycle: error, then normal turnaround
      vec[20] = '{1'b1, 5'd2,  3'd1, 1'b1, 24'h000004, 1'b0};
      vec[21] = '{1'b1, 5'd25, 3'd1, 1'b1, 24'h000000, 1'b1};
      vec[22] = '{1'b0, 5'd0,  3'd0, 1'b0, 24'h000000, 1'b0};
      vec[23] = '{1'b0, 5'd0,  3'd0, 1'b1, 24'h000000, 1'b0};

      #2;
      chk("rst_drive_en", 0, 32'(drive_en), 32'h0);
      chk("rst_bus_idle", 0, 32'(bus_idle), 32'h1);
      chk("rst_err", 0, 32'(err_bad_sel), 32'h0);
      chk("rst_ready", 0, 32'(req_ready), 32'h1);
      chk("rst_drive_cycles", 0, 32'(drive_cycles), 32'h0);
      chk("rst_turn_cycles", 0, 32'(turn_cycles), 32'h0);

      @(negedge clk);
      clr = 1'b0;

      for (int i = 0; i < 24; i++) step(vec[i], "vec", i);

      // Clear during the third cycle of an R3 len-7 grant
      t = '{1'b1, 5'd3, 3'd7, 1'b1, 24'h000008, 1'b0};
      step(t, "clr_seq", 0);
      t = '{1'b0, 5'd0, 3'd0, 1'b0, 24'h000008, 1'b0};
      step(t, "clr_seq", 1);
      step(t, "clr_seq", 2);
      clr = 1'b1;
      #1;
      chk("clr_async_drive_en", 0, 32'(drive_en), 32'h0);
      chk("clr_async_bus_idle", 0, 32'(bus_idle), 32'h1);
      chk("clr_async_ready", 0, 32'(req_ready), 32'h1);
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("clr_release_ready", 0, 32'(req_ready), 32'h1);
      @(negedge clk);
      chk("clr_release_drive_en", 0, 32'(drive_en), 32'h0);
      chk("clr_release_drive_cycles", 0, 32'(drive_cycles), 32'h0);

      // MDR -> HI again from a clean clear, for the stats counters
      for (int i = 11; i <= 16; i++) step(vec[i], "stats_seq", i);
`ifdef BUS_DRIVE_STATS_EN
      chk("stats_drive_cycles", 0, 32'(drive_cycles), 32'd3);
      chk("stats_turn_cycles", 0, 32'(turn_cycles), 32'd2);
`else
      chk("stats_drive_cycles", 0, 32'(drive_cycles), 32'd0);
      chk("stats_turn_cycles", 0, 32'(turn_cycles), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
